// File: rtl/chi_rn_req_tx.sv
// CHI REQ-channel RN-side link transmitter: link-activation FSM, L-credit accounting,
// credit-gated flit forwarding and LCrdReturn on teardown. Optional perf counters: CHI_REQ_TX_PERF_EN.
module chi_rn_req_tx #(
    parameter int FLIT_W     = 117,
    parameter int MAX_CRD    = 15,
    parameter int OPCODE_LSB = 42,
    localparam int CW        = $clog2(MAX_CRD + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              link_en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [FLIT_W-1:0] req_flit,
    output logic              tx_link_active_req,
    input  logic              tx_link_active_ack,
    output logic              tx_req_flit_pend,
    output logic              tx_req_flitv,
    output logic [FLIT_W-1:0] tx_req_flit,
    input  logic              tx_req_lcrdv,
    output logic [1:0]        link_state,
    output logic [CW-1:0]     crd_cnt,
    output logic              proto_err,
    output logic [31:0]       perf_flit_cnt,
    output logic [31:0]       perf_nocrd_cyc
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_ACT   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DEACT = 2'd3
    } state_t;

    localparam logic [CW-1:0] MAX_C      = CW'(MAX_CRD);
    localparam logic [5:0]    OPC_LCRD_RET = 6'h00;

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_crd, w_crd_nxt;
    logic                r_err, w_err_nxt;
    logic                r_flitv_p1;
    logic [FLIT_W-1:0]   r_flit_p1;
    logic                r_pend;
    logic                w_accept;
    logic                w_ret;
    logic                w_consume;
    logic                w_ack_lost_deact;
    logic [FLIT_W-1:0]   w_ret_flit;

    // Ready depends only on registered state so an lcrdv never opens ready in its own cycle.
    assign req_ready        = (r_state == ST_RUN) && (r_crd != '0);
    assign w_accept         = req_valid && req_ready;
    assign w_ret            = (r_state == ST_DEACT) && tx_link_active_ack && (r_crd != '0);
    assign w_consume        = w_accept || w_ret;
    assign w_ack_lost_deact = (r_state == ST_DEACT) && !tx_link_active_ack;

    always_comb begin
        w_ret_flit = '0;
        w_ret_flit[OPCODE_LSB +: 6] = OPC_LCRD_RET;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_crd_nxt   = r_crd;
        w_err_nxt   = r_err;
        case (r_state)
            ST_STOP: begin
                if (link_en && !tx_link_active_ack) w_state_nxt = ST_ACT;
                if (tx_req_lcrdv) w_err_nxt = 1'b1;
            end
            ST_ACT: begin
                if (tx_link_active_ack) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!tx_link_active_ack) begin
                    w_state_nxt = ST_DEACT;
                    w_err_nxt   = 1'b1;
                end else if (!link_en) begin
                    w_state_nxt = ST_DEACT;
                end
            end
            ST_DEACT: begin
                if (!tx_link_active_ack) begin
                    w_state_nxt = ST_STOP;
                    if (r_crd != '0) w_err_nxt = 1'b1;
                    w_crd_nxt = '0;
                end
            end
            default: w_state_nxt = ST_STOP;
        endcase
        // Credit accounting outside STOP; an ack loss in DEACTIVATE forfeits everything held.
        if ((r_state != ST_STOP) && !w_ack_lost_deact) begin
            if (tx_req_lcrdv && !w_consume) begin
                if (r_crd == MAX_C) w_err_nxt = 1'b1;
                else                w_crd_nxt = r_crd + CW'(1);
            end else if (!tx_req_lcrdv && w_consume) begin
                w_crd_nxt = r_crd - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_STOP;
            r_crd      <= '0;
            r_err      <= 1'b0;
            r_flitv_p1 <= 1'b0;
            r_flit_p1  <= '0;
            r_pend     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_crd      <= w_crd_nxt;
            r_err      <= w_err_nxt;
            r_flitv_p1 <= w_consume;
            if (w_accept)   r_flit_p1 <= req_flit;
            else if (w_ret) r_flit_p1 <= w_ret_flit;
            r_pend     <= (w_state_nxt == ST_RUN) ||
                          ((w_state_nxt == ST_DEACT) && (w_crd_nxt != '0));
        end
    end

    assign tx_link_active_req = (r_state == ST_ACT) || (r_state == ST_RUN);
    assign tx_req_flit_pend   = r_pend;
    assign tx_req_flitv       = r_flitv_p1;
    assign tx_req_flit        = r_flit_p1;
    assign link_state         = r_state;
    assign crd_cnt            = r_crd;
    assign proto_err          = r_err;

`ifdef CHI_REQ_TX_PERF_EN
    logic [31:0] r_perf_flit;
    logic [31:0] r_perf_nocrd;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_flit  <= '0;
            r_perf_nocrd <= '0;
        end else begin
            if (w_accept) r_perf_flit <= r_perf_flit + 32'd1;
            if ((r_state == ST_RUN) && req_valid && (r_crd == '0))
                r_perf_nocrd <= r_perf_nocrd + 32'd1;
        end
    end

    assign perf_flit_cnt  = r_perf_flit;
    assign perf_nocrd_cyc = r_perf_nocrd;
`else
    assign perf_flit_cnt  = '0;
    assign perf_nocrd_cyc = '0;
`endif

endmodule
